seq_detector_param: RTL



---
 rtl/seq_detector_param_if.sv | 36 +++
 rtl/seq_detector_param.sv | 98 +++++++++
 2 files changed

// File: rtl/seq_detector_param_if.sv
// Bus between a serial bit source and the parametrised pattern detector.
// The optional match_count signal exists only when SEQ_DET_COUNT_EN is defined.
interface seq_detector_param_if #(
  parameter int N       = 4,
  parameter int COUNT_W = 8
);
  logic               in_valid;
  logic               in_bit;
  logic               load;
  logic [N-1:0]       load_pattern;
  logic               overlap_en;
  logic               match;
`ifdef SEQ_DET_COUNT_EN
  logic [COUNT_W-1:0] match_count;

  modport master (
    output in_valid, in_bit, load, load_pattern, overlap_en,
    input  match, match_count
  );

  modport slave (
    input  in_valid, in_bit, load, load_pattern, overlap_en,
    output match, match_count
  );
`else
  modport master (
    output in_valid, in_bit, load, load_pattern, overlap_en,
    input  match
  );

  modport slave (
    input  in_valid, in_bit, load, load_pattern, overlap_en,
    output match
  );
`endif
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with runtime-loadable N-bit pattern,
// overlapping / non-overlapping detection and a registered one-cycle match pulse.
// Optional saturating match counter enabled by the SEQ_DET_COUNT_EN macro.
module seq_detector_param #(
  parameter int           N               = 4,
  parameter logic [N-1:0] DEFAULT_PATTERN = 4'b1011,
  parameter int           COUNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_detector_param_if.slave  bus
);

  localparam int FILL_W = $clog2(N + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
  localparam logic [FILL_W-1:0] FILL_HIT  = FILL_W'(N - 1);

  // Elaboration-time range checks on the configuration
  if ((N < 2) || (N > 32)) begin : g_bad_n
    $error("seq_detector_param: N must be in 2..32");
  end
  if ((COUNT_W < 1) || (COUNT_W > 32)) begin : g_bad_count_w
    $error("seq_detector_param: COUNT_W must be in 1..32");
  end

  logic [N-1:0]      pattern_q;
  logic [N-1:0]      hist_q;
  logic [FILL_W-1:0] fill_q;
  logic              match_q;

  logic [N-1:0]      hist_d;
  logic [FILL_W-1:0] fill_inc_d;
  logic              hit_d;

  // Candidate history, saturating fill increment and hit decision for an accepted bit
  always_comb begin
    hist_d     = {hist_q[N-2:0], bus.in_bit};
    hit_d      = 1'b0;
    fill_inc_d = fill_q;
    if (fill_q == FILL_FULL) begin
      fill_inc_d = fill_q;
    end else begin
      fill_inc_d = fill_q + FILL_W'(1);
    end
    if ((fill_q >= FILL_HIT) && (hist_d == pattern_q)) begin
      hit_d = 1'b1;
    end else begin
      hit_d = 1'b0;
    end
  end

  // Detector state: reset beats load, load beats data; stale history is masked by fill
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pattern_q <= DEFAULT_PATTERN;
      hist_q    <= {N{1'b0}};
      fill_q    <= {FILL_W{1'b0}};
      match_q   <= 1'b0;
    end else if (bus.load) begin
      pattern_q <= bus.load_pattern;
      hist_q    <= {N{1'b0}};
      fill_q    <= {FILL_W{1'b0}};
      match_q   <= 1'b0;
    end else if (bus.in_valid) begin
      hist_q  <= hist_d;
      match_q <= hit_d;
      if (hit_d && !bus.overlap_en) begin
        fill_q <= {FILL_W{1'b0}};
      end else begin
        fill_q <= fill_inc_d;
      end
    end else begin
      match_q <= 1'b0;
    end
  end

  assign bus.match = match_q;

`ifdef SEQ_DET_COUNT_EN
  logic [COUNT_W-1:0] count_q;

  // Saturating match counter, cleared by reset and by pattern load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= {COUNT_W{1'b0}};
    end else if (bus.load) begin
      count_q <= {COUNT_W{1'b0}};
    end else if (bus.in_valid && hit_d && (count_q != {COUNT_W{1'b1}})) begin
      count_q <= count_q + COUNT_W'(1);
    end else begin
      count_q <= count_q;
    end
  end

  assign bus.match_count = count_q;
`endif

endmodule
